alu_result_checker: RTL and testbench

Synthesizable self-checking monitor for the 8-bit ALU. It sits on the ALU output side: it accepts observed transactions (`ctrl`, `x`, `y` and the ALU's `carry`/`out`), recomputes the expected result internally, and counts passes and failures. It replaces golden-pattern comparison in simulation and provides on-chip pass/fail status for FPGA bring-up.

---
 rtl/alu_result_checker.sv | 217 +++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Self-checking monitor for the 8-bit ALU. Observed transactions (opcode,
//   operands, observed carry/result) are accepted one per cycle, the expected
//   result is recomputed through a two-stage pipeline, and pass/fail counts are
//   accumulated for a run of N_VECTORS transactions.
//
// Parameters
//   N_VECTORS : transactions per run (1..65535, must fit in CNT_W bits)
//   CNT_W     : width of pass, fail and index counters
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   start          : one-cycle pulse, begins a run from IDLE or DONE
//   in_valid       : observed transaction present
//   in_ready       : checker accepts a transaction this cycle
//   ctrl, x, y     : opcode and operands applied to the ALU
//   carry, out     : observed ALU carry and result
//   mismatch       : one-cycle pulse when a compared transaction fails
//   pass_cnt       : passing transactions (saturating)
//   fail_cnt       : failing transactions (saturating)
//   first_fail_idx : index of the first failing transaction
//   first_fail_vld : first_fail_idx holds a valid index
//   done           : all N_VECTORS transactions have been compared
module alu_result_checker #(
  parameter int unsigned N_VECTORS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic             carry,
  input  logic [7:0]       out,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_N   = CNT_W'(N_VECTORS);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [CNT_W-1:0] r_ff_idx;
  logic             r_ff_vld;
  logic             r_mismatch;
  logic             r_done;

  // Stage 1: captured inputs of an accepted transaction
  logic             r_s1_vld;
  logic [3:0]       r_s1_ctrl;
  logic [7:0]       r_s1_x;
  logic [7:0]       r_s1_y;
  logic             r_s1_carry;
  logic [7:0]       r_s1_out;
  logic [CNT_W-1:0] r_s1_idx;

  // Stage 2: expected and observed values side by side
  logic             r_s2_vld;
  logic [7:0]       r_s2_exp_out;
  logic             r_s2_exp_c;
  logic [7:0]       r_s2_obs_out;
  logic             r_s2_obs_c;
  logic             r_s2_cmp_c;
  logic [CNT_W-1:0] r_s2_idx;

  logic             w_accept;
  logic [7:0]       w_exp_out;
  logic             w_exp_c;
  logic             w_s2_fail;

  assign in_ready = (r_state == S_RUN) && (r_idx < LP_N);
  assign w_accept = in_valid && in_ready;

  // Reference ALU evaluated on stage-1 contents
  always_comb begin
    w_exp_out = '0;
    w_exp_c   = 1'b0;
    case (r_s1_ctrl)
      4'd0:    {w_exp_c, w_exp_out} = {1'b0, r_s1_x} + {1'b0, r_s1_y};
      4'd1:    {w_exp_c, w_exp_out} = {1'b0, r_s1_x} - {1'b0, r_s1_y};
      4'd2:    w_exp_out = r_s1_x & r_s1_y;
      4'd3:    w_exp_out = r_s1_x | r_s1_y;
      4'd4:    w_exp_out = ~r_s1_x;
      4'd5:    w_exp_out = r_s1_x ^ r_s1_y;
      4'd6:    w_exp_out = ~(r_s1_x | r_s1_y);
      4'd7:    w_exp_out = r_s1_y << r_s1_x[2:0];
      4'd8:    w_exp_out = r_s1_y >> r_s1_x[2:0];
      4'd9:    w_exp_out = {r_s1_x[7], r_s1_x[7:1]};
      4'd10:   w_exp_out = {r_s1_x[6:0], r_s1_x[7]};
      4'd11:   w_exp_out = {r_s1_x[0], r_s1_x[7:1]};
      4'd12:   w_exp_out = {7'b0, (r_s1_x == r_s1_y)};
      default: w_exp_out = '0;
    endcase
  end

  // Carry only participates for ADD/SUB
  assign w_s2_fail = (r_s2_exp_out != r_s2_obs_out) ||
                     (r_s2_cmp_c && (r_s2_exp_c != r_s2_obs_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld     <= 1'b0;
      r_s1_ctrl    <= '0;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_s1_carry   <= 1'b0;
      r_s1_out     <= '0;
      r_s1_idx     <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_exp_out <= '0;
      r_s2_exp_c   <= 1'b0;
      r_s2_obs_out <= '0;
      r_s2_obs_c   <= 1'b0;
      r_s2_cmp_c   <= 1'b0;
      r_s2_idx     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_ctrl  <= ctrl;
        r_s1_x     <= x;
        r_s1_y     <= y;
        r_s1_carry <= carry;
        r_s1_out   <= out;
        r_s1_idx   <= r_idx;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_exp_out <= w_exp_out;
        r_s2_exp_c   <= w_exp_c;
        r_s2_obs_out <= r_s1_out;
        r_s2_obs_c   <= r_s1_carry;
        r_s2_cmp_c   <= (r_s1_ctrl[3:1] == 3'b000);
        r_s2_idx     <= r_s1_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_ff_idx   <= '0;
      r_ff_vld   <= 1'b0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_idx    <= '0;
            r_pass   <= '0;
            r_fail   <= '0;
            r_ff_idx <= '0;
            r_ff_vld <= 1'b0;
            r_done   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_idx <= r_idx + LP_ONE;
          end
          if (r_s2_vld) begin
            if (w_s2_fail) begin
              r_mismatch <= 1'b1;
              if (r_fail != '1) begin
                r_fail <= r_fail + LP_ONE;
              end
              if (!r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff_idx <= r_s2_idx;
              end
            end else if (r_pass != '1) begin
              r_pass <= r_pass + LP_ONE;
            end
          end
          // Once the last accept has left stage 1, the entry in stage 2 is
          // being counted at this same edge, so done rises with the final
          // counter update.
          if ((r_idx == LP_N) && !r_s1_vld) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mismatch       = r_mismatch;
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_vld = r_ff_vld;
  assign done           = r_done;

endmodule

// File: tb/tb_alu_result_checker.sv
// Testbench for alu_result_checker: directed runs from the test plan plus a
// randomized phase, all compared against a transaction-level model.
module tb_alu_result_checker;

  localparam int unsigned N = 6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        carry;
  logic [7:0]  out;
  logic        mismatch;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] first_fail_idx;
  logic        first_fail_vld;
  logic        done;

  alu_result_checker #(.N_VECTORS(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ctrl(ctrl), .x(x), .y(y), .carry(carry), .out(out),
    .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted transaction remembers the edge it was accepted on,
  // its index, and whether it should fail; results are visible 2 edges later.
  typedef struct {
    int e;
    int idx;
    bit f;
  } ent_t;

  ent_t q[$];
  int   cyc;
  bit   m_started;
  int   m_acc;
  int   n_chk;
  int   n_pass;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Returns {carry, out} as a 9-bit value in an int
  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0:  return (a + b) & 'h1FF;
      1:  return (a - b) & 'h1FF;
      2:  return a & b;
      3:  return a | b;
      4:  return 255 - a;
      5:  return a ^ b;
      6:  return 255 - (a | b);
      7:  return (b << (a % 8)) & 255;
      8:  return b >> (a % 8);
      9:  return (a >= 128) ? ((a >> 1) | 128) : (a >> 1);
      10: return ((a << 1) | (a >> 7)) & 255;
      11: return ((a >> 1) | (a << 7)) & 255;
      12: return (a == b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_fail(input int op, input int a, input int b,
                                 input int c, input int o);
    int e;
    e = ref_alu(op, a, b);
    if (o != (e % 256)) return 1'b1;
    if (op < 2 && c != (e / 256)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_done(input int k);
    if (!m_started || m_acc != int'(N)) return 1'b0;
    foreach (q[i]) if (q[i].e + 2 > k) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compare_outputs();
    int ep, ef, effi, em;
    bit effv;
    ep = 0; ef = 0; effi = 0; effv = 0; em = 0;
    foreach (q[i]) begin
      if (q[i].e + 2 <= cyc) begin
        if (q[i].f) begin
          ef++;
          if (!effv) begin
            effv = 1'b1;
            effi = q[i].idx;
          end
          if (q[i].e + 2 == cyc) em = 1;
        end else begin
          ep++;
        end
      end
    end
    check_val("mismatch", int'(mismatch), em);
    check_val("pass_cnt", int'(pass_cnt), ep);
    check_val("fail_cnt", int'(fail_cnt), ef);
    check_val("first_fail_vld", int'(first_fail_vld), int'(effv));
    check_val("first_fail_idx", int'(first_fail_idx), effi);
    check_val("done", int'(done), int'(model_done(cyc)));
  endtask

  // One clock cycle: drive, check in_ready, clock, then check outputs.
  task automatic tick(input bit v, input int op, input int a, input int b,
                      input int c, input int o, input bit st);
    bit rdy, restart;
    in_valid = v;
    ctrl     = 4'(op);
    x        = 8'(a);
    y        = 8'(b);
    carry    = 1'(c);
    out      = 8'(o);
    start    = st;
    rdy      = m_started && (m_acc < int'(N));
    check_val("in_ready", int'(in_ready), int'(rdy));
    restart = st && (!m_started || model_done(cyc));
    if (v && rdy) begin
      q.push_back('{cyc + 1, m_acc, is_fail(op, a, b, c, o)});
      m_acc++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (restart) begin
      q.delete();
      m_acc     = 0;
      m_started = 1'b1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_in_ready"}, int'(in_ready), 0);
    check_val({pfx, "_mismatch"}, int'(mismatch), 0);
    check_val({pfx, "_pass"}, int'(pass_cnt), 0);
    check_val({pfx, "_fail"}, int'(fail_cnt), 0);
    check_val({pfx, "_ffidx"}, int'(first_fail_idx), 0);
    check_val({pfx, "_ffvld"}, int'(first_fail_vld), 0);
    check_val({pfx, "_done"}, int'(done), 0);
  endtask

  task automatic rand_txn(output int op, output int a, output int b,
                          output int c, output int o);
    int e;
    op = int'($urandom_range(0, 15));
    a  = int'($urandom_range(0, 255));
    b  = int'($urandom_range(0, 255));
    e  = ref_alu(op, a, b);
    o  = e % 256;
    c  = (op < 2) ? e / 256 : int'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) o = o ^ (1 << $urandom_range(0, 7));
    if (op < 2 && $urandom_range(0, 5) == 0) c = 1 - c;
  endtask

  int op, a, b, c, o;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; m_started = 0; m_acc = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    ctrl = '0; x = '0; y = '0; carry = 1'b0; out = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Run A: all-pass directed transactions
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 3, 10, 0, 13, 0);
    tick(1, 1, 3, 10, 1, 'hF9, 0);
    tick(1, 2, 'hF0, 'h3C, 0, 'h30, 0);
    tick(1, 12, 5, 5, 0, 1, 0);
    tick(1, 5, 'hAA, 'h55, 1, 'hFF, 0);
    check_val("runA_done_early", int'(done), 0);
    tick(1, 7, 3, 'h81, 0, 'h08, 0);
    idle(1);
    check_val("runA_done_acc+1", int'(done), 0);
    idle(1);
    check_val("runA_done_acc+2", int'(done), 1);
    check_val("runA_pass", int'(pass_cnt), 6);
    check_val("runA_fail", int'(fail_cnt), 0);
    check_val("runA_ffvld", int'(first_fail_vld), 0);
    idle(2);

    // Run B: injected faults at index 2 and 5, start pulsed during RUN
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 9, 'h80, 0, 0, 'hC0, 0);
    tick(1, 11, 'h01, 0, 0, 'h80, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 'hFF, 'h01, 0, 'h00, 0);
    tick(1, 14, 'h12, 'h34, 1, 0, 0);
    idle(1);
    tick(1, 7, 3, 'h81, 0, 'h08, 0);
    tick(1, 3, 'h0F, 'hF0, 0, 'h00, 0);
    idle(2);
    check_val("runB_pass", int'(pass_cnt), 4);
    check_val("runB_fail", int'(fail_cnt), 2);
    check_val("runB_ffidx", int'(first_fail_idx), 2);
    check_val("runB_ffvld", int'(first_fail_vld), 1);
    check_val("runB_done", int'(done), 1);

    // Back-to-back: start in DONE clears, in_valid held for 9 cycles
    tick(0, 0, 0, 0, 0, 0, 1);
    check_val("restart_fail_clr", int'(fail_cnt), 0);
    check_val("restart_done_clr", int'(done), 0);
    for (int i = 0; i < 9; i++) tick(1, 2, i, 'hFF, 0, i, 0);
    check_val("b2b_ready_low", int'(in_ready), 0);
    idle(2);
    check_val("b2b_pass", int'(pass_cnt), 6);

    // Randomized runs with gaps and occasional stray start pulses
    for (int i = 0; i < 400; i++) begin
      bit st;
      rand_txn(op, a, b, c, o);
      if (!m_started || model_done(cyc)) st = ($urandom_range(0, 1) == 1);
      else st = ($urandom_range(0, 19) == 0);
      tick($urandom_range(0, 3) != 0, op, a, b, c, o, st);
    end
    idle(3);

    // Async reset one cycle after an accept
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 'hFF, 'h01, 0, 'h00, 0);
    tick(1, 2, 1, 1, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    q.delete();
    m_acc = 0;
    m_started = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    tick(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 3, i, 'h10, 0, i | 'h10, 0);
    idle(3);
    check_val("post_rst_pass", int'(pass_cnt), 6);
    check_val("post_rst_fail", int'(fail_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
